fetch_decode_queue: RTL and testbench

Parametrised fetch-to-decode buffer that replaces the single-entry IF/ID pipeline register. Holds up to DEPTH fetch bundles of LANES instructions each (instruction, lane valid, predicted-taken bit, PC) in a circular queue. Uses valid/ready handshakes on both sides, a whole-queue flush, and a decoder replay path that rewrites the head bundle in place. Sits between the fetch stage and the decoder.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fdq_storage.sv | 27 ++
 rtl/fetch_decode_queue.sv | 110 +++++++++++
 tb/tb_fetch_decode_queue.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths and lane slice helpers for the fetch-to-decode queue
package fetch_pkg;

  localparam int FETCH_LANES = 2;
  localparam int FETCH_DEPTH = 4;
  localparam int FETCH_ILEN  = 16;
  localparam int FETCH_PCLEN = 16;

  function automatic int instr_lsb(input int lane, input int ilen);
    return lane * ilen;
  endfunction

  function automatic int pc_lsb(input int lane, input int pclen);
    return lane * pclen;
  endfunction

endpackage

// File: rtl/fdq_storage.sv
// rtl/fdq_storage.sv - bundle register array: tail write port, head rewrite port, async head read
module fdq_storage #(
  parameter int DEPTH = 4,
  parameter int W     = 68,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_rw_en,
  input  logic [AW-1:0] i_raddr,
  input  logic [W-1:0]  i_rw_data,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // The controller guarantees the tail and head never coincide while a rewrite is live.
  always_ff @(posedge clk) begin
    if (i_we)    r_mem[i_waddr] <= i_wdata;
    if (i_rw_en) r_mem[i_raddr] <= i_rw_data;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_decode_queue.sv
// rtl/fetch_decode_queue.sv - circular fetch-bundle queue between fetch and decode
// with flush and in-place head replay from the decoder.
module fetch_decode_queue
  import fetch_pkg::*;
#(
  parameter int LANES = FETCH_LANES,
  parameter int DEPTH = FETCH_DEPTH,
  parameter int ILEN  = FETCH_ILEN,
  parameter int PCLEN = FETCH_PCLEN,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*ILEN-1:0]  in_instr,
  input  logic [LANES-1:0]       in_lv,
  input  logic [LANES-1:0]       in_pred,
  input  logic [LANES*PCLEN-1:0] in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*ILEN-1:0]  out_instr,
  output logic [LANES-1:0]       out_lv,
  output logic [LANES-1:0]       out_pred,
  output logic [LANES*PCLEN-1:0] out_pc,
  input  logic                   replay_valid,
  input  logic [LANES*ILEN-1:0]  replay_instr,
  input  logic [LANES-1:0]       replay_lv,
  input  logic [LANES-1:0]       replay_pred,
  input  logic [LANES*PCLEN-1:0] replay_pc,
  output logic [CW-1:0]          count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int W  = LANES * (ILEN + PCLEN + 2);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_IX = AW'(DEPTH - 1);

  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_count;

  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_push;
  logic          w_pop;
  logic          w_replay;
  logic          w_rewrite;
  logic [W-1:0]  w_rdata;

  logic [LANES*ILEN-1:0]  w_h_instr;
  logic [LANES*PCLEN-1:0] w_h_pc;
  logic [LANES-1:0]       w_h_pred;
  logic [LANES-1:0]       w_h_lv;

  assign w_in_ready  = (r_count < FULL);
  assign w_out_valid = (r_count != '0);

  // An all-invalid bundle still completes the handshake but takes no slot.
  assign w_push    = in_valid && w_in_ready && !flush && (|in_lv);
  assign w_replay  = w_out_valid && replay_valid && !flush;
  assign w_rewrite = w_replay && (|replay_lv);
  assign w_pop     = w_out_valid && !flush &&
                     (replay_valid ? !(|replay_lv) : out_ready);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= (r_wr == LAST_IX) ? '0 : r_wr + 1'b1;
      if (w_pop)  r_rd <= (r_rd == LAST_IX) ? '0 : r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  fdq_storage #(
    .DEPTH (DEPTH),
    .W     (W),
    .AW    (AW)
  ) u_storage (
    .clk       (clk),
    .i_we      (w_push),
    .i_waddr   (r_wr),
    .i_wdata   ({in_instr, in_pc, in_pred, in_lv}),
    .i_rw_en   (w_rewrite),
    .i_raddr   (r_rd),
    .i_rw_data ({replay_instr, replay_pc, replay_pred, replay_lv}),
    .o_rdata   (w_rdata)
  );

  assign {w_h_instr, w_h_pc, w_h_pred, w_h_lv} = w_rdata;

  // Stale array contents must never leak out while the queue is empty.
  assign out_instr = w_out_valid ? w_h_instr : '0;
  assign out_pc    = w_out_valid ? w_h_pc    : '0;
  assign out_pred  = w_out_valid ? w_h_pred  : '0;
  assign out_lv    = w_out_valid ? w_h_lv    : '0;

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign count     = r_count;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb/tb_fetch_decode_queue.sv - directed self-checking bench for fetch_decode_queue
module tb_fetch_decode_queue;
  import fetch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush;
  logic        in_valid, in_ready, out_valid, out_ready, replay_valid;
  logic [31:0] in_instr, in_pc, out_instr, out_pc, replay_instr, replay_pc;
  logic [1:0]  in_lv, in_pred, out_lv, out_pred, replay_lv, replay_pred;
  logic [2:0]  count;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_instr, b_in_pc, b_out_instr, b_out_pc;
  logic [1:0]  b_in_lv, b_out_lv, b_out_pred;
  logic [1:0]  b_count;

  int checks = 0;
  int errors = 0;

  fetch_decode_queue #(.LANES(2), .DEPTH(4), .ILEN(16), .PCLEN(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_lv(in_lv), .in_pred(in_pred), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_lv(out_lv), .out_pred(out_pred), .out_pc(out_pc),
    .replay_valid(replay_valid), .replay_instr(replay_instr), .replay_lv(replay_lv),
    .replay_pred(replay_pred), .replay_pc(replay_pc),
    .count(count)
  );

  fetch_decode_queue #(.LANES(2), .DEPTH(3), .ILEN(16), .PCLEN(16)) dut3 (
    .clk(clk), .reset(reset), .flush(1'b0),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_instr(b_in_instr), .in_lv(b_in_lv), .in_pred(2'b00), .in_pc(b_in_pc),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_instr(b_out_instr), .out_lv(b_out_lv), .out_pred(b_out_pred), .out_pc(b_out_pc),
    .replay_valid(1'b0), .replay_instr(32'h0), .replay_lv(2'b00),
    .replay_pred(2'b00), .replay_pc(32'h0),
    .count(b_count)
  );

  function automatic logic [31:0] mk_pc(input int base);
    return {16'(base + 1), 16'(base)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; replay_valid = 1'b0;
    in_instr = '0; in_lv = 2'b11; in_pred = '0; in_pc = '0;
    replay_instr = '0; replay_lv = '0; replay_pred = '0; replay_pc = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_instr = '0; b_in_lv = 2'b11; b_in_pc = '0;
    tick(); tick();
    reset = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if ({out_instr, out_pc, out_lv, out_pred} !== 68'h0) begin
      errors++; $display("FAIL reset_out_fields got %h/%h/%b/%b want 0", out_instr, out_pc, out_lv, out_pred);
    end
  endtask

  task automatic test_fill_drain();
    in_valid = 1'b1; in_lv = 2'b11; out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_pc = mk_pc(16'h10 + 2*k); in_instr = {16'h2000 + 16'(k), 16'h1000 + 16'(k)};
      tick();
    end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %b want 0", in_ready); end
    in_pc = mk_pc(16'h18);
    tick();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fifth_push_count got %0d want 4", count); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_pc !== mk_pc(16'h10 + 2*k) || out_instr !== {16'h2000 + 16'(k), 16'h1000 + 16'(k)}) begin
        errors++; $display("FAIL drain_%0d got pc %h instr %h want pc %h", k, out_pc, out_instr, mk_pc(16'h10 + 2*k));
      end
      tick();
    end
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL drain_empty got count %0d valid %b want 0 0", count, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_steady();
    int bad = 0;
    in_valid = 1'b1; out_ready = 1'b1; in_lv = 2'b11;
    for (int i = 0; i < 20; i++) begin
      in_pc = mk_pc(16'h100 + 2*i); in_instr = 32'hC0DE_0000 + i;
      tick();
      checks++; if (count !== 3'd1 || out_pc !== mk_pc(16'h100 + 2*i) || out_instr !== 32'hC0DE_0000 + i) begin
        errors++; bad++;
        if (bad < 4) $display("FAIL steady_%0d got count %0d pc %h want 1 %h", i, count, out_pc, mk_pc(16'h100 + 2*i));
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL steady_drain got %0d want 0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_replay();
    in_valid = 1'b1; in_lv = 2'b11; in_instr = {16'hB456, 16'hA123}; in_pc = mk_pc(16'h50); in_pred = 2'b01;
    tick();
    in_valid = 1'b0; in_pred = 2'b00;
    replay_valid = 1'b1; replay_lv = 2'b10; replay_instr = {16'hB456, 16'h0000};
    replay_pc = {16'h0051, 16'h0000}; replay_pred = 2'b10; out_ready = 1'b1;
    tick();
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL replay_count got %0d want 1", count); end
    checks++; if (out_lv !== 2'b10 || out_instr[instr_lsb(1, 16) +: 16] !== 16'hB456 || out_pred !== 2'b10) begin
      errors++; $display("FAIL replay_head got lv %b instr %h pred %b want 10 b456xxxx 10", out_lv, out_instr, out_pred);
    end
    checks++; if (out_pc[pc_lsb(1, 16) +: 16] !== 16'h0051) begin
      errors++; $display("FAIL replay_pc got %h want 0051", out_pc[31:16]);
    end
    replay_lv = 2'b00; out_ready = 1'b0;
    tick();
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL replay_zero_pop got count %0d valid %b want 0 0", count, out_valid);
    end
    replay_valid = 1'b0;
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL replay_empty_ignored got %0d want 0", count); end
  endtask

  task automatic test_zero_lv();
    in_valid = 1'b1; in_lv = 2'b11; in_pc = mk_pc(16'h60); in_instr = 32'h1111_2222;
    tick();
    in_lv = 2'b00; in_pc = mk_pc(16'h62);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_lv_ready got %b want 1", in_ready); end
    tick();
    checks++; if (count !== 3'd1 || out_pc !== mk_pc(16'h60)) begin
      errors++; $display("FAIL zero_lv_count got %0d pc %h want 1 %h", count, out_pc, mk_pc(16'h60));
    end
    in_valid = 1'b0; in_lv = 2'b11; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_lv = 2'b11;
    for (int k = 0; k < 3; k++) begin
      in_pc = mk_pc(16'h70 + 2*k); in_instr = 32'hF000_0000 + k;
      tick();
    end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count got %0d want 3", count); end
    flush = 1'b1; out_ready = 1'b1; in_pc = mk_pc(16'h78);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_state got count %0d valid %b want 0 0", count, out_valid);
    end
    checks++; if ({out_instr, out_pc, out_lv, out_pred} !== 68'h0) begin
      errors++; $display("FAIL flush_out_zero got %h/%h/%b want 0", out_instr, out_pc, out_lv);
    end
    in_valid = 1'b1; in_pc = mk_pc(16'h90); in_instr = 32'h9999_8888;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pc !== mk_pc(16'h90) || out_instr !== 32'h9999_8888) begin
      errors++; $display("FAIL flush_repush got valid %b pc %h want 1 %h", out_valid, out_pc, mk_pc(16'h90));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int bad = 0;
    b_in_valid = 1'b1; b_out_ready = 1'b1; b_in_lv = 2'b11;
    for (int i = 0; i < 10; i++) begin
      b_in_pc = mk_pc(16'h300 + 2*i); b_in_instr = 32'hAB00_0000 + i;
      tick();
      checks++; if (b_count !== 2'd1 || b_out_pc !== mk_pc(16'h300 + 2*i) || b_out_instr !== 32'hAB00_0000 + i) begin
        errors++; bad++;
        if (bad < 4) $display("FAIL wrap_%0d got count %0d pc %h want 1 %h", i, b_count, b_out_pc, mk_pc(16'h300 + 2*i));
      end
    end
    b_out_ready = 1'b0; b_in_pc = mk_pc(16'h400);
    tick();
    checks++; if (b_count !== 2'd2 || b_out_pc !== mk_pc(16'h312)) begin
      errors++; $display("FAIL wrap_hold got count %0d pc %h want 2 %h", b_count, b_out_pc, mk_pc(16'h312));
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; b_in_valid = 1'b0;
    checks++; if (b_count !== 2'd0 || b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
      errors++; $display("FAIL wrap_reset got count %0d ready %b valid %b want 0 1 0", b_count, b_in_ready, b_out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_steady();
    test_replay();
    test_zero_lv();
    test_flush();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
